// File: rtl/vsi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vsi_pkg
// Purpose  : Shared state encoding and widths for the vector op arbiter.
// Revision : 1.0
// ============================================================================
package vsi_pkg;

  localparam logic [1:0] S_ARB        = 2'd0;
  localparam logic [1:0] S_ISSUE      = 2'd1;
  localparam logic [1:0] S_WAIT_START = 2'd2;
  localparam logic [1:0] S_WAIT_DONE  = 2'd3;

  localparam int VSI_OP_W   = 32;
  localparam int VSI_PERF_W = 16;

endpackage
`default_nettype wire

// File: rtl/vsi_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : vsi_rr_pick
// Purpose  : Combinational round-robin picker (first request at/after pointer).
// Revision : 1.0
// ============================================================================
module vsi_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_rr_ptr,
  output logic [N_REQ-1:0] o_gnt_oh,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_any
);

  localparam int c_PW = IDX_W + 1;

  // Position is reduced modulo N_REQ so non-power-of-two sizes never alias.
  always_comb begin
    logic [c_PW-1:0] v_pos;
    v_pos     = '0;
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    o_gnt_any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      v_pos = {1'b0, i_rr_ptr} + c_PW'(k);
      if (v_pos >= c_PW'(N_REQ)) begin
        v_pos = v_pos - c_PW'(N_REQ);
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!o_gnt_any && i_req[i] && (v_pos == c_PW'(i))) begin
          o_gnt_oh[i] = 1'b1;
          o_gnt_idx   = IDX_W'(i);
          o_gnt_any   = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vsi_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vsi_op_arbiter
// Purpose  : Round-robin sharing of the vector coprocessor, one op in flight.
//            Define VSI_ARB_PERF_EN to add grant/stall performance counters.
// Revision : 1.0
// ============================================================================
module vsi_op_arbiter
  import vsi_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int OP_W  = VSI_OP_W,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  vsi_clk,
  input  logic                  vsi_rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*OP_W-1:0] req_op,
  input  logic [N_REQ-1:0]      req_lmul,
  input  logic [N_REQ-1:0]      req_sew,
  output logic [N_REQ-1:0]      req_done,
  output logic                  vsi_op_valid,
  input  logic                  vsi_op_ready,
  output logic [OP_W-1:0]       vsi_op,
  output logic                  vsi_lmul,
  output logic                  vsi_sew,
  input  logic                  vsi_cop_idle,
  output logic                  arb_busy,
  output logic [IDX_W-1:0]      arb_owner
`ifdef VSI_ARB_PERF_EN
  ,
  output logic [N_REQ*VSI_PERF_W-1:0] perf_grants,
  output logic [VSI_PERF_W-1:0]       perf_stall
`endif
);

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_owner;
  logic [OP_W-1:0]  r_op;
  logic             r_lmul;
  logic             r_sew;

  logic [N_REQ-1:0] w_pick_oh;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic             w_accept;
  logic [IDX_W-1:0] w_ptr_next;
  logic [OP_W-1:0]  w_sel_op;
  logic             w_sel_lmul;
  logic             w_sel_sew;

  vsi_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req     (req_valid),
    .i_rr_ptr  (r_rr_ptr),
    .o_gnt_oh  (w_pick_oh),
    .o_gnt_idx (w_pick_idx),
    .o_gnt_any (w_pick_any)
  );

  assign w_accept   = (r_state == S_ARB) && w_pick_any;
  assign w_ptr_next = (w_pick_idx == IDX_W'(N_REQ - 1)) ? '0 : w_pick_idx + IDX_W'(1);

  always_comb begin
    w_sel_op   = '0;
    w_sel_lmul = 1'b0;
    w_sel_sew  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick_oh[i]) begin
        w_sel_op   = req_op[i*OP_W +: OP_W];
        w_sel_lmul = req_lmul[i];
        w_sel_sew  = req_sew[i];
      end
    end
  end

  always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
    if (!vsi_rst_n) begin
      r_state  <= S_ARB;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_op     <= '0;
      r_lmul   <= 1'b0;
      r_sew    <= 1'b0;
    end else begin
      case (r_state)
        S_ARB: begin
          if (w_pick_any) begin
            r_op     <= w_sel_op;
            r_lmul   <= w_sel_lmul;
            r_sew    <= w_sel_sew;
            r_owner  <= w_pick_idx;
            r_rr_ptr <= w_ptr_next;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE:      if (vsi_op_ready)  r_state <= S_WAIT_START;
        S_WAIT_START: if (!vsi_cop_idle) r_state <= S_WAIT_DONE;
        S_WAIT_DONE:  if (vsi_cop_idle)  r_state <= S_ARB;
        default:                         r_state <= S_ARB;
      endcase
    end
  end

  assign req_ready    = (r_state == S_ARB) ? w_pick_oh : '0;
  assign vsi_op_valid = (r_state == S_ISSUE);
  assign vsi_op       = r_op;
  assign vsi_lmul     = r_lmul;
  assign vsi_sew      = r_sew;
  assign arb_busy     = (r_state != S_ARB);
  assign arb_owner    = r_owner;

  // Completion: the coprocessor has been seen busy and is idle again.
  always_comb begin
    req_done = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_done[i] = (r_state == S_WAIT_DONE) && vsi_cop_idle && (r_owner == IDX_W'(i));
    end
  end

`ifdef VSI_ARB_PERF_EN
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_perf_grant
    logic [VSI_PERF_W-1:0] r_cnt;
    always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
      if (!vsi_rst_n) begin
        r_cnt <= '0;
      end else if (w_accept && w_pick_oh[gi] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + VSI_PERF_W'(1);
      end
    end
    assign perf_grants[gi*VSI_PERF_W +: VSI_PERF_W] = r_cnt;
  end

  logic [VSI_PERF_W-1:0] r_stall;
  always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
    if (!vsi_rst_n) begin
      r_stall <= '0;
    end else if ((r_state == S_ISSUE) && !vsi_op_ready && (r_stall != '1)) begin
      r_stall <= r_stall + VSI_PERF_W'(1);
    end
  end
  assign perf_stall = r_stall;
`endif

endmodule
`default_nettype wire
